// File: rtl/wb_irq_ctrl_pkg.sv
// Shared constants and helpers for the Wishbone interrupt controller.
package wb_irq_pkg;

    // Register word indices (bus address bits [3:2])
    localparam logic [1:0] IRQ_REG_STATUS = 2'd0;
    localparam logic [1:0] IRQ_REG_ENABLE = 2'd1;
    localparam logic [1:0] IRQ_REG_CLEAR  = 2'd2;
    localparam logic [1:0] IRQ_REG_TIMER  = 2'd3;

    // Interrupt source bit positions in the pending vector
    localparam int unsigned SRC_TUBE_IRQ = 0;
    localparam int unsigned SRC_TUBE_NMI = 1;
    localparam int unsigned SRC_TICK     = 2;
    localparam int unsigned NUM_SRC      = 3;

    // Reset routing: IRQ from tube IRQ, FIRQ from tube NMI
    localparam logic [NUM_SRC-1:0] IRQ_EN_RST  = 3'b001;
    localparam logic [NUM_SRC-1:0] FIRQ_EN_RST = 3'b010;

    // Merge a bus write into an existing register image, honouring byte lanes
    function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                               input logic [31:0] wr_val,
                                               input logic [3:0]  sel);
        logic [31:0] mask;
        for (int unsigned i = 0; i < 4; i++) begin
            mask[i*8 +: 8] = {8{sel[i]}};
        end
        return (old_val & ~mask) | (wr_val & mask);
    endfunction

endpackage

// File: rtl/wb_irq_ctrl_if.sv
// Wishbone slave bus bundle for the interrupt controller.
interface wb_irq_ctrl_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [1:0]  wb_adr_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wb_irq_ctrl_sync.sv
// Multi-flop input synchroniser with one extra flop holding the previous
// synchronised value, for edge detection downstream.
module irq_sync #(
    parameter int unsigned SYNC_STAGES = 3
) (
    input  logic clk,
    input  logic rst_b,
    input  logic d_i,
    output logic sync_o,
    output logic prev_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the asynchronous input through the chain; reset clears every flop
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign prev_o = prev_q;

endmodule

// File: rtl/wb_irq_ctrl.sv
// Wishbone slave interrupt controller: synchronises the Tube parasite
// interrupt lines, latches NMI edges and timer ticks, and routes each
// source to the a23 IRQ and/or FIRQ input.
module wb_irq_ctrl
    import wb_irq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 3,
    parameter int unsigned TIMER_WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst_b,
    wb_irq_ctrl_if.slave  wb,
    input  logic          p_irq_b,
    input  logic          p_nmi_b,
    output logic          o_irq,
    output logic          o_firq
);

    // Synchronised, active-high source levels
    logic irq_lvl;
    logic irq_prev_unused;
    logic nmi_lvl;
    logic nmi_prev;

    // Lines are inverted before synchronising so a cleared chain reads as
    // "not asserted" straight out of reset.
    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_irq (
        .clk    (clk),
        .rst_b  (rst_b),
        .d_i    (~p_irq_b),
        .sync_o (irq_lvl),
        .prev_o (irq_prev_unused)
    );

    irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_nmi (
        .clk    (clk),
        .rst_b  (rst_b),
        .d_i    (~p_nmi_b),
        .sync_o (nmi_lvl),
        .prev_o (nmi_prev)
    );

    logic                   ack_q,      ack_d;
    logic [31:0]            dat_q,      dat_d;
    logic [NUM_SRC-1:0]     irq_en_q,   irq_en_d;
    logic [NUM_SRC-1:0]     firq_en_q,  firq_en_d;
    logic [TIMER_WIDTH-1:0] reload_q,   reload_d;
    logic                   tmr_en_q,   tmr_en_d;
    logic [TIMER_WIDTH-1:0] cnt_q,      cnt_d;
    logic                   nmi_pend_q, nmi_pend_d;
    logic                   tick_pend_q, tick_pend_d;
    logic                   o_irq_q,    o_irq_d;
    logic                   o_firq_q,   o_firq_d;

    logic               req;
    logic               wr;
    logic [NUM_SRC-1:0] pend;
    logic [31:0]        status_rd;
    logic [31:0]        enable_rd;
    logic [31:0]        timer_rd;
    logic [31:0]        enable_wr;
    logic [31:0]        timer_wr;
    logic [31:0]        rd_val;
    logic [2:1]         clr;
    logic               expire;
    logic               nmi_edge;

    // Register views, bus decode, pending/timer next-state and output routing
    always_comb begin
        req = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
        wr  = req & wb.wb_we_i;

        pend               = '0;
        pend[SRC_TUBE_IRQ] = irq_lvl;
        pend[SRC_TUBE_NMI] = nmi_pend_q;
        pend[SRC_TICK]     = tick_pend_q;

        status_rd      = '0;
        status_rd[2:0] = pend;
        status_rd[4]   = irq_lvl;
        status_rd[5]   = nmi_lvl;

        enable_rd       = '0;
        enable_rd[2:0]  = irq_en_q;
        enable_rd[10:8] = firq_en_q;

        timer_rd                    = '0;
        timer_rd[TIMER_WIDTH-1:0]   = reload_q;
        timer_rd[31]                = tmr_en_q;

        enable_wr = lane_merge(enable_rd, wb.wb_dat_i, wb.wb_sel_i);
        timer_wr  = lane_merge(timer_rd,  wb.wb_dat_i, wb.wb_sel_i);

        rd_val = '0;
        case (wb.wb_adr_i)
            IRQ_REG_STATUS: rd_val = status_rd;
            IRQ_REG_ENABLE: rd_val = enable_rd;
            IRQ_REG_CLEAR:  rd_val = '0;
            IRQ_REG_TIMER:  rd_val = timer_rd;
            default:        rd_val = '0;
        endcase

        ack_d = req;
        dat_d = (req && !wb.wb_we_i) ? rd_val : '0;

        irq_en_d  = irq_en_q;
        firq_en_d = firq_en_q;
        if (wr && wb.wb_adr_i == IRQ_REG_ENABLE) begin
            irq_en_d  = enable_wr[2:0];
            firq_en_d = enable_wr[10:8];
        end

        reload_d = reload_q;
        tmr_en_d = tmr_en_q;
        if (wr && wb.wb_adr_i == IRQ_REG_TIMER) begin
            reload_d = timer_wr[TIMER_WIDTH-1:0];
            tmr_en_d = timer_wr[31];
        end

        clr = '0;
        if (wr && wb.wb_adr_i == IRQ_REG_CLEAR && wb.wb_sel_i[0]) begin
            clr = wb.wb_dat_i[2:1];
        end

        // Counter: a TIMER write always reloads (with the newly written
        // value); otherwise it runs only while enabled and reloads after 0.
        expire = tmr_en_q && (cnt_q == '0);
        cnt_d  = cnt_q;
        if (wr && wb.wb_adr_i == IRQ_REG_TIMER) begin
            cnt_d = timer_wr[TIMER_WIDTH-1:0];
        end else if (tmr_en_q) begin
            cnt_d = expire ? reload_q : cnt_q - 1'b1;
        end

        // Set events take priority over a simultaneous clear
        nmi_edge    = nmi_lvl & ~nmi_prev;
        nmi_pend_d  = nmi_edge | (nmi_pend_q  & ~clr[SRC_TUBE_NMI]);
        tick_pend_d = expire   | (tick_pend_q & ~clr[SRC_TICK]);

        o_irq_d  = |(pend & irq_en_q);
        o_firq_d = |(pend & firq_en_q);
    end

    // State update; reset drops any in-flight access and restores defaults
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            ack_q       <= 1'b0;
            dat_q       <= '0;
            irq_en_q    <= IRQ_EN_RST;
            firq_en_q   <= FIRQ_EN_RST;
            reload_q    <= '0;
            tmr_en_q    <= 1'b0;
            cnt_q       <= '0;
            nmi_pend_q  <= 1'b0;
            tick_pend_q <= 1'b0;
            o_irq_q     <= 1'b0;
            o_firq_q    <= 1'b0;
        end else begin
            ack_q       <= ack_d;
            dat_q       <= dat_d;
            irq_en_q    <= irq_en_d;
            firq_en_q   <= firq_en_d;
            reload_q    <= reload_d;
            tmr_en_q    <= tmr_en_d;
            cnt_q       <= cnt_d;
            nmi_pend_q  <= nmi_pend_d;
            tick_pend_q <= tick_pend_d;
            o_irq_q     <= o_irq_d;
            o_firq_q    <= o_firq_d;
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = dat_q;
    assign o_irq       = o_irq_q;
    assign o_firq      = o_firq_q;

endmodule

// File: doc/wb_irq_ctrl.md
# wb_irq_ctrl

Wishbone slave interrupt controller between the Tube parasite interrupt outputs and the a23 core's `i_irq`/`i_firq` inputs. It replaces the fixed three-flop synchronisers in the LX9 ARM2 top level and adds:

- per-source IRQ/FIRQ routing,
- latched edge sources with write-1-to-clear,
- a programmable periodic tick timer.

It occupies a new `wb_switch` slave window and is software-visible to the ARM client ROM.

## Interface

Parameters:

- `SYNC_STAGES`, 3: flops in each input synchroniser chain (minimum 2).
- `TIMER_WIDTH`, 16: width of the tick timer reload register and counter (maximum 31).

Ports:

- `clk` in 1: system clock, the 16 MHz core clock.
- `rst_b` in 1: reset, synchronous, active-low.
- `wb_cyc_i` in 1: Wishbone cycle.
- `wb_stb_i` in 1: Wishbone strobe.
- `wb_we_i` in 1: write enable.
- `wb_adr_i` in 2: word address, taken from bus address bits [3:2].
- `wb_sel_i` in 4: byte lane selects.
- `wb_dat_i` in 32: write data.
- `wb_dat_o` out 32: read data.
- `wb_ack_o` out 1: single-cycle acknowledge.
- `p_irq_b` in 1: Tube parasite IRQ, active-low, asynchronous level.
- `p_nmi_b` in 1: Tube parasite NMI, active-low, asynchronous.
- `o_irq` out 1: to a23 `i_irq`.
- `o_firq` out 1: to a23 `i_firq`.

## Operation

Sources and pending bits:

- Source 0, tube IRQ: level-sensitive. `pend[0]` equals the synchronised `~p_irq_b`. It is not clearable.
- Source 1, tube NMI: edge-latched. `pend[1]` is set on a synchronised falling edge of `p_nmi_b`.
- Source 2, timer tick: `pend[2]` is set when the counter expires.

Registers, selected by `wb_adr_i`:

- 0, STATUS, read-only:
  - [2:0] = `pend`
  - [4] = synchronised irq level
  - [5] = synchronised nmi level
  - all other bits 0
- 1, ENABLE, read/write:
  - [2:0] = `irq_en`, reset value 3'b001
  - [10:8] = `firq_en`, reset value 3'b010
  - Reset routing reproduces the current design: IRQ from tube IRQ, FIRQ from tube NMI.
- 2, CLEAR, write-only, reads 0:
  - Writing 1 to bit 1 or bit 2 clears the matching pending bit.
  - Bit 0 is ignored.
- 3, TIMER, read/write:
  - [TIMER_WIDTH-1:0] = `reload`, reset value 0.
  - [31] = `tmr_en`, reset value 0.
  - Reads return the register value, not the live count.

Write rules:

- Writes honour `wb_sel_i` per byte lane.
- A write to CLEAR takes effect only when `wb_sel_i[0]` is set.

Timer:

- Counter runs only while `tmr_en` is 1.
- The counter is loaded with `reload` on any TIMER write and on the cycle after it expires.
- The counter decrements every `clk`.
- Expiry means the counter equals 0 while enabled. Expiry sets `pend[2]`.
- Period is `reload`+1 cycles. `reload` = 0 gives a tick every cycle.
- While `tmr_en` is 0 the counter holds its value. The next TIMER write reloads it.

Outputs:

- `o_irq` is registered from |(`pend` & `irq_en`).
- `o_firq` is registered from |(`pend` & `firq_en`).

Boundary conditions:

- A set event and a CLEAR write to the same bit in the same cycle: set wins, so the bit stays 1.
- An NMI edge while `pend[1]` is already 1: no change, no counting.
- Disabling a source in ENABLE does not clear its pending bit.
- `rst_b` low at any clock edge:
  - clears all synchroniser flops, `pend`, the counter and `wb_ack_o`;
  - loads the reset values of ENABLE and TIMER;
  - drives `o_irq`=0 and `o_firq`=0.
  - This applies mid-access too. An access in flight at reset is dropped without an ack.

## Timing

- Reset values of outputs: `wb_ack_o`=0, `wb_dat_o`=0, `o_irq`=0, `o_firq`=0.
- Wishbone handshake:
  - `wb_ack_o` rises one cycle after `wb_cyc_i & wb_stb_i & ~wb_ack_o` is sampled high.
  - `wb_ack_o` is high for exactly one cycle.
  - Back-to-back accesses take 2 cycles each.
  - `wb_dat_o` is valid in the ack cycle and 0 otherwise.
  - A register write takes effect at the same edge that raises the ack.
- Input latency: an input change sampled at edge E appears in the synchronised level at edge E+`SYNC_STAGES`-1.
- Edge detection compares the last synchroniser stage against one extra flop, so `pend[1]` sets at edge E+`SYNC_STAGES`.
- `o_irq`/`o_firq` follow `pend` by one cycle.
- With defaults, `p_irq_b` low sampled at edge 1 gives `o_irq` high after edge 4. This matches the existing three-flop delay.
- Timer expiry at edge T: `pend[2]` set at T+1, output asserted at T+2.

## Structure

- Shared package `wb_irq_pkg`:
  - register index constants `IRQ_REG_STATUS`/`ENABLE`/`CLEAR`/`TIMER` = 0..3;
  - source bit constants `SRC_TUBE_IRQ`=0, `SRC_TUBE_NMI`=1, `SRC_TICK`=2;
  - reset constants for ENABLE.
- One sub-module, `irq_sync`: a `SYNC_STAGES`-deep synchroniser with a registered previous-value output, instantiated twice.
- Timer, register file and Wishbone logic stay inline.

## Test plan

- **Reset defaults.** Hold `rst_b` low for 2 cycles, then read all registers. Expect STATUS=0, ENABLE=0x00000201, TIMER=0, `o_irq`=`o_firq`=0.
- **IRQ level latency.** Drive `p_irq_b` low at edge 1. Expect `o_irq`=1 after edge 4. Release and expect `o_irq`=0 four edges later. A CLEAR write of 0x1 has no effect.
- **NMI latch and clear.** Pulse `p_nmi_b` low for 1 cycle. Expect `o_firq`=1 and STATUS[1]=1 until CLEAR is written with 0x2. In a separate run, inject an edge in the same cycle as the CLEAR write and expect `pend[1]` to stay 1.
- **Timer and routing.** Write TIMER=0x80000009 and ENABLE=0x004. Expect `pend[2]` every 10 cycles and `o_irq`=1. Write ENABLE=0x400 and expect `o_firq`=1 with `o_irq`=0.
- **Byte lanes.** Write ENABLE with `wb_sel_i`=4'b0010 and data 0xFFFFFFFF. Expect ENABLE=0x00000701.
- **Reset mid-access.** Assert `rst_b` low during `wb_stb_i` with the timer running and pending bits set. Expect no ack, all state at reset values, and the next access acking normally.
